// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory port arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Master indices: instruction fetch and load/store.
    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational 2-way round-robin chooser: a lone requester wins outright,
// a tie goes to the master that was not granted last.
module rr_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_id,
    output logic       any
);

    // Pick the winner from the current request vector.
    always_comb begin
        any    = |req;
        gnt_id = IFU;
        if (req[IFU] && req[LSU]) begin
            gnt_id = ~last_grant;
        end else if (req[LSU]) begin
            gnt_id = LSU;
        end
    end

endmodule : rr_pick

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between IFU (master 0) and LSU (master 1).
// One transaction outstanding; the grant is held from request acceptance
// until the response handshake completes. Payload passes through untouched.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 (IFU)
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wmask,
    output logic                m0_rsp_valid,
    input  logic                m0_rsp_ready,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    output logic                m0_rsp_err,
    // master 1 (LSU)
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wmask,
    output logic                m1_rsp_valid,
    input  logic                m1_rsp_ready,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                m1_rsp_err,
    // slave
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wmask,
    input  logic                s_rsp_valid,
    output logic                s_rsp_ready,
    input  logic [DATA_W-1:0]   s_rsp_rdata,
    input  logic                s_rsp_err,
    // debug
    output logic                grant_id,
    output logic                busy
);

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   pick_id, pick_any;

    rr_pick u_rr_pick (
        .req        ({m1_req_valid, m0_req_valid}),
        .last_grant (last_grant_q),
        .gnt_id     (pick_id),
        .any        (pick_any)
    );

    // State, grant and round-robin history registers; synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of the others; blocking here would create order-dependent races.
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= IFU;
            last_grant_q <= LSU;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for request then response handshake.
    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (s_req_valid && s_req_ready) begin
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (s_rsp_valid && s_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Route the granted master's request to the slave and the slave's response back.
    always_comb begin
        s_req_valid  = 1'b0;
        s_req_addr   = '0;
        s_req_wen    = 1'b0;
        s_req_wdata  = '0;
        s_req_wmask  = '0;
        s_rsp_ready  = 1'b0;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m1_rsp_valid = 1'b0;
        m0_rsp_rdata = '0;
        m1_rsp_rdata = '0;
        m0_rsp_err   = 1'b0;
        m1_rsp_err   = 1'b0;
        if (state_q == REQ) begin
            if (grant_q == LSU) begin
                s_req_valid  = m1_req_valid;
                s_req_addr   = m1_req_addr;
                s_req_wen    = m1_req_wen;
                s_req_wdata  = m1_req_wdata;
                s_req_wmask  = m1_req_wmask;
                m1_req_ready = s_req_ready;
            end else begin
                s_req_valid  = m0_req_valid;
                s_req_addr   = m0_req_addr;
                s_req_wen    = m0_req_wen;
                s_req_wdata  = m0_req_wdata;
                s_req_wmask  = m0_req_wmask;
                m0_req_ready = s_req_ready;
            end
        end
        if (state_q == RESP) begin
            if (grant_q == LSU) begin
                m1_rsp_valid = s_rsp_valid;
                m1_rsp_rdata = s_rsp_rdata;
                m1_rsp_err   = s_rsp_err;
                s_rsp_ready  = m1_rsp_ready;
            end else begin
                m0_rsp_valid = s_rsp_valid;
                m0_rsp_rdata = s_rsp_rdata;
                m0_rsp_err   = s_rsp_err;
                s_rsp_ready  = m0_rsp_ready;
            end
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    // Protocol checks: no slave response outside RESP, no request withdrawal in REQ.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_rsp_only_in_resp : assert (state_q == RESP || !s_rsp_valid);
            a_req_held_in_req  : assert (state_q != REQ ||
                                         (grant_q == LSU ? m1_req_valid : m0_req_valid));
        end
    end

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit later, well away from the edge.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                m0_req_valid, m0_req_ready, m0_req_wen;
    logic [ADDR_W-1:0]   m0_req_addr;
    logic [DATA_W-1:0]   m0_req_wdata;
    logic [DATA_W/8-1:0] m0_req_wmask;
    logic                m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [DATA_W-1:0]   m0_rsp_rdata;
    logic                m1_req_valid, m1_req_ready, m1_req_wen;
    logic [ADDR_W-1:0]   m1_req_addr;
    logic [DATA_W-1:0]   m1_req_wdata;
    logic [DATA_W/8-1:0] m1_req_wmask;
    logic                m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [DATA_W-1:0]   m1_rsp_rdata;
    logic                s_req_valid, s_req_ready, s_req_wen;
    logic [ADDR_W-1:0]   s_req_addr;
    logic [DATA_W-1:0]   s_req_wdata;
    logic [DATA_W/8-1:0] s_req_wmask;
    logic                s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [DATA_W-1:0]   s_rsp_rdata;
    logic                grant_id, busy;

    int errors = 0;
    int checks = 0;
    int busy_cycles;
    logic [5:0] exp_order;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_wen(m0_req_wen), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_wen(m1_req_wen), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .m1_rsp_err(m1_rsp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_wen(s_req_wen), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .s_rsp_err(s_rsp_err),
        .grant_id(grant_id), .busy(busy)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req_valid = 0; m0_req_addr = '0; m0_req_wen = 0; m0_req_wdata = '0; m0_req_wmask = '0;
        m0_rsp_ready = 0;
        m1_req_valid = 0; m1_req_addr = '0; m1_req_wen = 0; m1_req_wdata = '0; m1_req_wmask = '0;
        m1_rsp_ready = 0;
        s_req_ready = 0; s_rsp_valid = 0; s_rsp_rdata = '0; s_rsp_err = 0;

        // ---- reset state ----
        tick(); tick();
        settle();
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_s_req_valid", s_req_valid, 0);
        check("rst_req_ready", {m0_req_ready, m1_req_ready}, 0);
        check("rst_s_rsp_ready", s_rsp_ready, 0);
        rst = 1'b0;

        // ---- single m0 read: 1 request wait + 2 response waits -> 5 busy cycles ----
        tick();
        busy_cycles = 0;
        m0_req_valid = 1; m0_req_addr = 32'h8000_0000; m0_req_wen = 0;
        m0_rsp_ready = 1;
        settle();
        check("t1_idle_s_req_valid", s_req_valid, 0);
        tick();                                   // REQ, slave not ready
        settle();
        busy_cycles += int'(busy);
        check("t1_s_req_valid", s_req_valid, 1);
        check("t1_s_req_addr", s_req_addr, 32'h8000_0000);
        check("t1_m0_req_ready_wait", m0_req_ready, 0);
        tick();                                   // REQ, slave ready
        s_req_ready = 1;
        settle();
        busy_cycles += int'(busy);
        check("t1_m0_req_ready", m0_req_ready, 1);
        check("t1_m1_req_ready", m1_req_ready, 0);
        tick();                                   // RESP wait 1
        m0_req_valid = 0;
        settle();
        busy_cycles += int'(busy);
        check("t1_m0_rsp_valid_wait", m0_rsp_valid, 0);
        tick();                                   // RESP wait 2
        settle();
        busy_cycles += int'(busy);
        tick();                                   // RESP, data returns
        s_rsp_valid = 1; s_rsp_rdata = 32'h0000_0413;
        settle();
        busy_cycles += int'(busy);
        check("t1_m0_rsp_valid", m0_rsp_valid, 1);
        check("t1_m0_rsp_rdata", m0_rsp_rdata, 32'h0000_0413);
        check("t1_m1_rsp_valid", m1_rsp_valid, 0);
        check("t1_m1_rsp_rdata", m1_rsp_rdata, 0);
        check("t1_s_rsp_ready", s_rsp_ready, 1);
        tick();                                   // IDLE
        s_rsp_valid = 0;
        settle();
        busy_cycles += int'(busy);
        check("t1_busy_cycles", busy_cycles, 5);

        // ---- simultaneous requests after reset: m0 first, m1 one cycle after m0's response ----
        rst = 1;
        tick();
        rst = 0;
        m0_req_valid = 1; m0_req_addr = 32'h0000_0100;
        m1_req_valid = 1; m1_req_addr = 32'h0000_0200; m1_rsp_ready = 1;
        tick();                                   // REQ
        settle();
        check("t2_grant_first", grant_id, 0);
        check("t2_s_req_addr", s_req_addr, 32'h0000_0100);
        check("t2_m1_req_ready", m1_req_ready, 0);
        tick();                                   // RESP
        m0_req_valid = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'h11;
        settle();
        check("t2_m1_rsp_valid", m1_rsp_valid, 0);
        check("t2_s_req_valid_resp", s_req_valid, 0);
        tick();                                   // IDLE (K+1)
        s_rsp_valid = 0;
        settle();
        check("t2_s_req_valid_idle", s_req_valid, 0);
        tick();                                   // REQ (K+2)
        settle();
        check("t2_m1_s_req_valid", s_req_valid, 1);
        check("t2_grant_second", grant_id, 1);
        check("t2_m1_s_req_addr", s_req_addr, 32'h0000_0200);
        tick();                                   // RESP
        m1_req_valid = 0;
        s_rsp_valid = 1;
        tick();                                   // IDLE
        s_rsp_valid = 0;

        // ---- continuous contention, zero-wait slave: 0,1,0,1,0,1 in 3 cycles each ----
        exp_order = 6'b101010;
        m0_req_valid = 1; m1_req_valid = 1;
        for (int t = 0; t < 6; t++) begin
            settle();
            check("t3_idle_busy", busy, 0);
            tick();                               // REQ
            settle();
            check("t3_grant_order", grant_id, exp_order[t]);
            check("t3_s_req_addr", s_req_addr, exp_order[t] ? 32'h0000_0200 : 32'h0000_0100);
            tick();                               // RESP
            s_rsp_valid = 1;
            settle();
            check("t3_s_rsp_ready", s_rsp_ready, 1);
            tick();                               // IDLE
            s_rsp_valid = 0;
        end
        m0_req_valid = 0; m1_req_valid = 0;

        // ---- m1 write, error response routed to m1 only ----
        tick();
        m1_req_valid = 1; m1_req_addr = 32'h8000_0100; m1_req_wen = 1;
        m1_req_wdata = 32'hDEAD_BEEF; m1_req_wmask = 4'hF;
        tick();                                   // REQ
        settle();
        check("t4_grant", grant_id, 1);
        check("t4_s_req_addr", s_req_addr, 32'h8000_0100);
        check("t4_s_req_wen", s_req_wen, 1);
        check("t4_s_req_wdata", s_req_wdata, 32'hDEAD_BEEF);
        check("t4_s_req_wmask", s_req_wmask, 4'hF);
        check("t4_m1_req_ready", m1_req_ready, 1);
        check("t4_m0_req_ready", m0_req_ready, 0);
        tick();                                   // RESP
        m1_req_valid = 0; m1_req_wen = 0;
        s_rsp_valid = 1; s_rsp_err = 1; s_rsp_rdata = '0;
        settle();
        check("t4_m1_rsp_err", m1_rsp_err, 1);
        check("t4_m0_rsp_err", m0_rsp_err, 0);
        check("t4_m0_rsp_valid", m0_rsp_valid, 0);
        check("t4_m1_rsp_valid", m1_rsp_valid, 1);
        tick();                                   // IDLE
        s_rsp_valid = 0; s_rsp_err = 0;

        // ---- m0 stalls its response for 4 cycles; pending m1 must wait ----
        m0_req_valid = 1; m0_req_addr = 32'h8000_0004;
        tick();                                   // REQ
        settle();
        check("t5_grant", grant_id, 0);
        tick();                                   // RESP
        m0_req_valid = 0;
        m1_req_valid = 1; m1_req_addr = 32'h8000_0200;
        s_rsp_valid = 1; s_rsp_rdata = 32'h55; m0_rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t5_s_rsp_ready_stall", s_rsp_ready, 0);
            check("t5_busy_stall", busy, 1);
            check("t5_grant_stall", grant_id, 0);
            check("t5_m1_req_ready_stall", m1_req_ready, 0);
            tick();
        end
        m0_rsp_ready = 1;
        settle();
        check("t5_s_rsp_ready_release", s_rsp_ready, 1);
        check("t5_m0_rsp_rdata", m0_rsp_rdata, 32'h55);
        tick();                                   // IDLE
        s_rsp_valid = 0;
        settle();
        check("t5_idle_busy", busy, 0);
        tick();                                   // REQ for m1
        settle();
        check("t5_m1_granted", grant_id, 1);
        tick();                                   // RESP
        m1_req_valid = 0;
        s_rsp_valid = 1;
        tick();                                   // IDLE
        s_rsp_valid = 0;

        // ---- reset in RESP after an m0 grant; first post-reset tie must go to m0 ----
        m0_req_valid = 1; m0_req_addr = 32'h8000_0008;
        tick();                                   // REQ
        tick();                                   // RESP
        m0_req_valid = 0;
        settle();
        check("t6_busy_resp", busy, 1);
        rst = 1;
        m0_req_valid = 1; m1_req_valid = 1;
        tick();                                   // reset applied
        settle();
        check("t6_busy", busy, 0);
        check("t6_grant", grant_id, 0);
        check("t6_s_req_valid", s_req_valid, 0);
        check("t6_req_ready", {m0_req_ready, m1_req_ready}, 0);
        check("t6_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
        check("t6_s_rsp_ready", s_rsp_ready, 0);
        check("t6_s_req_addr", s_req_addr, 0);
        rst = 0;
        tick();                                   // REQ
        settle();
        check("t6_tie_grant", grant_id, 0);
        check("t6_s_req_addr_post", s_req_addr, 32'h8000_0008);
        tick();                                   // RESP
        m0_req_valid = 0;
        s_rsp_valid = 1;
        tick();                                   // IDLE
        s_rsp_valid = 0;
        m1_req_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
